fib_reg_sequencer: RTL

- Controller that drives the 2-read/1-write 32x32 register file to fill it with a Fibonacci-style series.
- Entry i is written with entry[i-2] + entry[i-1].
- The register file's reset seeds entries 0 and 1 with 1.
- Sits beside the register file in the lab top level, owns every register-file port, and gives the host a start/busy/done handshake.

---
 rtl/fib_seq_pkg.sv | 22 ++
 rtl/fib_reg_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fib_seq_pkg.sv
// -----------------------------------------------------------------------------
// fib_seq_pkg
//   Shared definitions for the Fibonacci register-file sequencer.
//   - ADDR_W / DATA_W : default register-file geometry (32 x 32)
//   - FIRST_IDX       : first entry the sequencer computes; entries below it
//                       are seeded by the register file reset
//   - state_e         : sequencer FSM states
// -----------------------------------------------------------------------------
package fib_seq_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int FIRST_IDX = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : fib_seq_pkg

// File: rtl/fib_reg_sequencer.sv
// -----------------------------------------------------------------------------
// fib_reg_sequencer
//   Drives a 2-read/1-write register file so that entry i = entry[i-2] +
//   entry[i-1] for i = 2 .. last_idx. Entries 0 and 1 are never written; the
//   register file reset seeds them with 1.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, last_idx       : host request (sampled in IDLE only) and highest
//                           entry to compute
//   busy, done            : busy from the cycle after acceptance until DONE is
//                           left; done is a one-cycle pulse in DONE
//   overflow              : sticky carry-out of any addition, cleared on start
//   result                : last value written, held until the next start
//   rf_r1_addr/rf_r2_addr : read addresses (entries i-2 / i-1)
//   rf_r3_addr/din/wr     : write port
//   rf_r1_dout/rf_r2_dout : read data, updated by the register file on negedge
//
// Handshake: start is a single-cycle request, accepted only when the FSM is
// in IDLE; the host sees busy=1 from the next cycle and waits for done.
// Requests arriving while busy are dropped, not queued.
//
// Timing: every output is a flop. Read addresses become valid on the posedge
// that enters RD, the register file captures data on the following negedge,
// and the sum is taken on the posedge that leaves RD, so the write strobe
// and data are registered into the WR cycle.
// -----------------------------------------------------------------------------
module fib_reg_sequencer
  import fib_seq_pkg::*;
#(
  parameter int ADDR_W = fib_seq_pkg::ADDR_W,
  parameter int DATA_W = fib_seq_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] rf_r1_addr,
  output logic [ADDR_W-1:0] rf_r2_addr,
  output logic [ADDR_W-1:0] rf_r3_addr,
  output logic [DATA_W-1:0] rf_r3_din,
  output logic              rf_r3_wr,
  input  logic [DATA_W-1:0] rf_r1_dout,
  input  logic [DATA_W-1:0] rf_r2_dout
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_IDX);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   r1_addr_q, r1_addr_d;
  logic [ADDR_W-1:0]   r2_addr_q, r2_addr_d;
  logic [ADDR_W-1:0]   r3_addr_q, r3_addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                wr_q, wr_d;

  // One extra bit keeps the carry-out for the sticky overflow flag.
  logic [DATA_W:0]     sum;

  assign sum = {1'b0, rf_r1_dout} + {1'b0, rf_r2_dout};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    r1_addr_d = r1_addr_q;
    r2_addr_d = r2_addr_q;
    r3_addr_d = r3_addr_q;
    din_d     = din_q;
    wr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          last_d   = last_idx;
          ovf_d    = 1'b0;
          result_d = '0;
          idx_d    = FIRST;
          if (last_idx < FIRST) begin
            state_d = DONE;
          end else begin
            state_d   = RD;
            r1_addr_d = FIRST - ADDR_W'(2);
            r2_addr_d = FIRST - ADDR_W'(1);
          end
        end
      end
      RD: begin
        // Read data was captured mid-cycle; register the write for WR.
        state_d   = WR;
        wr_d      = 1'b1;
        r3_addr_d = idx_q;
        din_d     = sum[DATA_W-1:0];
        result_d  = sum[DATA_W-1:0];
        ovf_d     = ovf_q | sum[DATA_W];
      end
      WR: begin
        // Compare before incrementing so idx never passes last (max 31).
        if (idx_q == last_q) begin
          state_d = DONE;
        end else begin
          state_d   = RD;
          idx_d     = idx_q + ADDR_W'(1);
          r1_addr_d = idx_q - ADDR_W'(1);
          r2_addr_d = idx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= FIRST;
      last_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      r1_addr_q <= '0;
      r2_addr_q <= '0;
      r3_addr_q <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      r1_addr_q <= r1_addr_d;
      r2_addr_q <= r2_addr_d;
      r3_addr_q <= r3_addr_d;
      din_q     <= din_d;
      wr_q      <= wr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign result     = result_q;
  assign rf_r1_addr = r1_addr_q;
  assign rf_r2_addr = r2_addr_q;
  assign rf_r3_addr = r3_addr_q;
  assign rf_r3_din  = din_q;
  assign rf_r3_wr   = wr_q;

endmodule : fib_reg_sequencer
